cache_miss_sequencer: RTL and testbench

Sequences all miss handling for the 4-way, 256-set, one-word-line write-back data cache that sits between the CPU and main memory. On a miss it stalls the CPU, writes back a dirty victim, refills load misses from memory, and then commits the line into the cache arrays in one cycle. It owns the main-memory request/acknowledge handshake and keeps saturating hit, miss and write-back statistics counters. The cache arrays and way selection are external; this block only decides when, and with what, they are updated.

---
 rtl/cache_pkg.sv | 19 +
 rtl/sat_counter.sv | 18 +
 rtl/cache_miss_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_cache_miss_sequencer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared types and geometry for the 4-way, 256-set, one-word-line data cache.
package cache_pkg;

   localparam int unsigned ADDR_W_DEFAULT = 32;
   localparam int unsigned DATA_W_DEFAULT = 32;
   localparam int unsigned NUM_WAYS       = 4;
   localparam int unsigned INDEX_W        = 8;
   localparam int unsigned TAG_W          = 22;
   // Byte-offset bits within a one-word line.
   localparam int unsigned OFFS_W         = ADDR_W_DEFAULT - TAG_W - INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WB     = 2'd1,
      ST_REFILL = 2'd2,
      ST_COMMIT = 2'd3
   } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst)
         count <= '0;
      else if (inc && (count != {CNT_W{1'b1}}))
         count <= count + CNT_W'(1);
   end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Miss handling for the write-back data cache: victim write-back, load refill,
// one-cycle commit into the arrays, memory handshake and statistics.
module cache_miss_sequencer
   import cache_pkg::*;
#(
   parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
   parameter int unsigned DATA_W = DATA_W_DEFAULT,
   parameter int unsigned CNT_W  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              hit,
   input  logic              victim_dirty,
   input  logic [ADDR_W-1:0] victim_addr,
   input  logic [DATA_W-1:0] victim_data,
   output logic              stall,
   output logic              fill_en,
   output logic              fill_store,
   output logic [DATA_W-1:0] fill_data,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  hit_count,
   output logic [CNT_W-1:0]  miss_count,
   output logic [CNT_W-1:0]  wb_count
);

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << OFFS_W) - 1);

   state_e            state, state_nxt;
   logic [ADDR_W-1:0] lat_addr, lat_addr_nxt;
   logic              lat_we, lat_we_nxt;
   logic              replay, replay_nxt;
   logic              fill_en_nxt, fill_store_nxt;
   logic [DATA_W-1:0] fill_data_nxt;
   logic              mem_req_nxt, mem_we_nxt;
   logic [ADDR_W-1:0] mem_addr_nxt;
   logic [DATA_W-1:0] mem_wdata_nxt;
   logic              hit_inc, miss_inc, wb_inc;
   logic              ack;

   assign ack   = mem_req & mem_ack;
   assign stall = (state != ST_IDLE) | (cpu_req & ~hit);

   // Next state, next registered outputs and counter strobes.
   always_comb begin
      state_nxt      = state;
      lat_addr_nxt   = lat_addr;
      lat_we_nxt     = lat_we;
      replay_nxt     = replay;
      fill_en_nxt    = 1'b0;
      fill_store_nxt = fill_store;
      fill_data_nxt  = fill_data;
      mem_req_nxt    = mem_req;
      mem_we_nxt     = mem_we;
      mem_addr_nxt   = mem_addr;
      mem_wdata_nxt  = mem_wdata;
      hit_inc        = 1'b0;
      miss_inc       = 1'b0;
      wb_inc         = 1'b0;

      case (state)
         ST_IDLE: begin
            replay_nxt = 1'b0;
            hit_inc    = cpu_req & hit & ~replay;
            if (cpu_req && !hit) begin
               miss_inc     = 1'b1;
               lat_addr_nxt = cpu_addr;
               lat_we_nxt   = cpu_we;
               if (victim_dirty) begin
                  state_nxt     = ST_WB;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = 1'b1;
                  mem_addr_nxt  = victim_addr;
                  mem_wdata_nxt = victim_data;
               end else if (cpu_we) begin
                  // One-word lines: a store overwrites the whole line, no refill.
                  state_nxt      = ST_COMMIT;
                  fill_en_nxt    = 1'b1;
                  fill_store_nxt = 1'b1;
               end else begin
                  state_nxt     = ST_REFILL;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = cpu_addr & WORD_MASK;
                  mem_wdata_nxt = '0;
               end
            end
         end
         ST_WB: begin
            if (ack) begin
               wb_inc = 1'b1;
               if (lat_we) begin
                  state_nxt      = ST_COMMIT;
                  mem_req_nxt    = 1'b0;
                  mem_we_nxt     = 1'b0;
                  mem_addr_nxt   = '0;
                  mem_wdata_nxt  = '0;
                  fill_en_nxt    = 1'b1;
                  fill_store_nxt = 1'b1;
               end else begin
                  state_nxt     = ST_REFILL;
                  mem_req_nxt   = 1'b1;
                  mem_we_nxt    = 1'b0;
                  mem_addr_nxt  = lat_addr & WORD_MASK;
                  mem_wdata_nxt = '0;
               end
            end
         end
         ST_REFILL: begin
            if (ack) begin
               state_nxt      = ST_COMMIT;
               fill_data_nxt  = mem_rdata;
               mem_req_nxt    = 1'b0;
               mem_we_nxt     = 1'b0;
               mem_addr_nxt   = '0;
               mem_wdata_nxt  = '0;
               fill_en_nxt    = 1'b1;
               fill_store_nxt = lat_we;
            end
         end
         ST_COMMIT: begin
            // Replayed access in the next IDLE cycle must not count as a hit.
            state_nxt      = ST_IDLE;
            replay_nxt     = 1'b1;
            fill_store_nxt = 1'b0;
            fill_data_nxt  = '0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         lat_addr   <= '0;
         lat_we     <= 1'b0;
         replay     <= 1'b0;
         fill_en    <= 1'b0;
         fill_store <= 1'b0;
         fill_data  <= '0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state      <= state_nxt;
         lat_addr   <= lat_addr_nxt;
         lat_we     <= lat_we_nxt;
         replay     <= replay_nxt;
         fill_en    <= fill_en_nxt;
         fill_store <= fill_store_nxt;
         fill_data  <= fill_data_nxt;
         mem_req    <= mem_req_nxt;
         mem_we     <= mem_we_nxt;
         mem_addr   <= mem_addr_nxt;
         mem_wdata  <= mem_wdata_nxt;
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (hit_inc),
      .count (hit_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (miss_inc),
      .count (miss_count)
   );

   sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (wb_inc),
      .count (wb_count)
   );

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Self-checking bench: transaction-level model of miss handling, memory responder
// with configurable wait states, and a 4-bit-counter build for saturation.
module tb_cache_miss_sequencer;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } txn_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, hit, victim_dirty, mem_ack;
   logic [31:0] cpu_addr, victim_addr, victim_data, mem_rdata;

   logic        stall, fill_en, fill_store, mem_req, mem_we;
   logic [31:0] fill_data, mem_addr, mem_wdata;
   logic [31:0] hit_count, miss_count, wb_count;

   logic        d4_stall, d4_fill_en, d4_fill_store, d4_mem_req, d4_mem_we;
   logic [31:0] d4_fill_data, d4_mem_addr, d4_mem_wdata;
   logic [3:0]  d4_hit_count, d4_miss_count, d4_wb_count;

   int passes = 0;
   int total  = 0;
   int m_hit  = 0;
   int m_miss = 0;
   int m_wb   = 0;

   always #5 clk = ~clk;

   cache_miss_sequencer #(.ADDR_W(32), .DATA_W(32), .CNT_W(32)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .hit(hit), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
      .victim_data(victim_data), .stall(stall), .fill_en(fill_en),
      .fill_store(fill_store), .fill_data(fill_data), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(hit_count),
      .miss_count(miss_count), .wb_count(wb_count)
   );

   cache_miss_sequencer #(.ADDR_W(32), .DATA_W(32), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
      .hit(hit), .victim_dirty(victim_dirty), .victim_addr(victim_addr),
      .victim_data(victim_data), .stall(d4_stall), .fill_en(d4_fill_en),
      .fill_store(d4_fill_store), .fill_data(d4_fill_data), .mem_req(d4_mem_req),
      .mem_we(d4_mem_we), .mem_addr(d4_mem_addr), .mem_wdata(d4_mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .hit_count(d4_hit_count),
      .miss_count(d4_miss_count), .wb_count(d4_wb_count)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passes++;
      else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
   endtask

   function automatic logic [63:0] sat4(input int v);
      return (v > 15) ? 64'd15 : 64'(v);
   endfunction

   task automatic check_counters(input string tag);
      chk({tag, "_hit"},   64'(hit_count),     64'(m_hit));
      chk({tag, "_miss"},  64'(miss_count),    64'(m_miss));
      chk({tag, "_wb"},    64'(wb_count),      64'(m_wb));
      chk({tag, "_hit4"},  64'(d4_hit_count),  sat4(m_hit));
      chk({tag, "_miss4"}, 64'(d4_miss_count), sat4(m_miss));
      chk({tag, "_wb4"},   64'(d4_wb_count),   sat4(m_wb));
   endtask

   // One complete miss with the bench acting as main memory.
   task automatic do_miss(input logic we, input logic dirty, input logic [31:0] addr,
                          input logic [31:0] vaddr, input logic [31:0] vdata,
                          input logic [31:0] rdata, input int wb_wait, input int rf_wait);
      txn_t        exp_q[$];
      txn_t        obs_q[$];
      int          stall_n = 0;
      int          fill_n  = 0;
      int          waits   = 0;
      bit          new_txn = 1'b1;
      bit          done    = 1'b0;
      bit          hold_ok = 1'b1;
      logic        obs_store = 1'bx;
      logic [31:0] obs_fdata = 'x;
      txn_t        cur;

      if (dirty) exp_q.push_back('{we: 1'b1, addr: vaddr, wdata: vdata});
      if (!we)   exp_q.push_back('{we: 1'b0, addr: addr & 32'hFFFF_FFFC, wdata: 32'h0});

      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; hit = 1'b0;
      victim_dirty = dirty; victim_addr = vaddr; victim_data = vdata;

      for (int cyc = 0; cyc < 200 && !done; cyc++) begin
         @(negedge clk);
         if (!stall) begin
            done = 1'b1;
            mem_ack = 1'b0;
            chk("idle_mem_req",  64'(mem_req),  64'd0);
            chk("idle_mem_addr", 64'(mem_addr), 64'd0);
         end else begin
            stall_n++;
            if (fill_en) begin
               fill_n++;
               obs_store = fill_store;
               obs_fdata = fill_data;
               hit = 1'b1;
            end
            if (mem_req) begin
               if (new_txn) begin
                  cur = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};
                  obs_q.push_back(cur);
                  waits   = mem_we ? wb_wait : rf_wait;
                  new_txn = 1'b0;
               end else if (mem_we !== cur.we || mem_addr !== cur.addr || mem_wdata !== cur.wdata) begin
                  hold_ok = 1'b0;
               end
               if (waits == 0) begin
                  mem_ack   = 1'b1;
                  mem_rdata = mem_we ? $urandom : rdata;
                  new_txn   = 1'b1;
               end else begin
                  waits--;
                  mem_ack   = 1'b0;
                  mem_rdata = $urandom;
               end
            end else begin
               mem_ack   = 1'($urandom_range(0, 1));
               mem_rdata = $urandom;
            end
         end
      end

      @(posedge clk); #1;
      cpu_req = 1'b0; hit = 1'b0;

      chk("miss_done", 64'(done), 64'd1);
      chk("mem_hold", 64'(hold_ok), 64'd1);
      chk("txn_count", 64'(obs_q.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         chk("txn_we",   64'(obs_q[i].we),   64'(exp_q[i].we));
         chk("txn_addr", 64'(obs_q[i].addr), 64'(exp_q[i].addr));
         if (exp_q[i].we) chk("txn_wdata", 64'(obs_q[i].wdata), 64'(exp_q[i].wdata));
      end
      chk("stall_cycles", 64'(stall_n),
          64'(2 + (dirty ? 1 + wb_wait : 0) + (we ? 0 : 1 + rf_wait)));
      chk("fill_en_count", 64'(fill_n), 64'd1);
      chk("fill_store", 64'(obs_store), 64'(we));
      if (!we) chk("fill_data", 64'(obs_fdata), 64'(rdata));

      m_miss++;
      if (dirty) m_wb++;
      check_counters("miss");
   endtask

   task automatic do_hits(input int n);
      bit stall_ok = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cpu_req = 1'b1; hit = 1'b1; cpu_we = 1'($urandom_range(0, 1));
         cpu_addr = $urandom; victim_dirty = 1'($urandom_range(0, 1));
         @(negedge clk);
         if (stall !== 1'b0 || mem_req !== 1'b0) stall_ok = 1'b0;
      end
      @(posedge clk); #1;
      cpu_req = 1'b0; hit = 1'b0;
      m_hit += n;
      chk("hits_no_stall", 64'(stall_ok), 64'd1);
   endtask

   task automatic do_idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         cpu_req = 1'b0; hit = 1'($urandom_range(0, 1));
         mem_ack = 1'($urandom_range(0, 1));
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
   endtask

   initial begin
      bit seen_req;

      rst = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; hit = 1'b0;
      victim_dirty = 1'b0; victim_addr = 32'h0; victim_data = 32'h0;
      mem_ack = 1'b0; mem_rdata = 32'h0;

      // Reset state; stall still follows cpu_req & !hit.
      @(negedge clk);
      chk("rst_stall_comb", 64'(stall), 64'd1);
      @(posedge clk); #1;
      cpu_req = 1'b0;
      @(negedge clk);
      chk("rst_stall",      64'(stall),      64'd0);
      chk("rst_fill_en",    64'(fill_en),    64'd0);
      chk("rst_fill_store", 64'(fill_store), 64'd0);
      chk("rst_fill_data",  64'(fill_data),  64'd0);
      chk("rst_mem_req",    64'(mem_req),    64'd0);
      chk("rst_mem_we",     64'(mem_we),     64'd0);
      chk("rst_mem_addr",   64'(mem_addr),   64'd0);
      chk("rst_mem_wdata",  64'(mem_wdata),  64'd0);
      chk("rst_d4_outputs", 64'(|{d4_stall, d4_fill_en, d4_fill_store, d4_fill_data,
                                  d4_mem_req, d4_mem_we, d4_mem_addr, d4_mem_wdata}), 64'd0);
      check_counters("rst");
      @(posedge clk); #1;
      rst = 1'b0;

      // Directed scenarios.
      do_miss(1'b0, 1'b0, 32'h0000_0104, 32'h0000_0800, 32'hAAAA_5555, 32'hDEAD_BEEF, 0, 2);
      do_miss(1'b0, 1'b1, 32'h0000_0208, 32'h0000_0404, 32'h1234_5678, 32'hCAFE_F00D, 0, 0);
      do_miss(1'b1, 1'b1, 32'h0000_030C, 32'h0000_070C, 32'h0BAD_CAFE, 32'h0, 0, 0);
      do_miss(1'b1, 1'b0, 32'h0000_0310, 32'h0000_0910, 32'h5A5A_5A5A, 32'h0, 0, 0);
      do_hits(10);
      check_counters("hits10");
      do_hits(20);
      check_counters("hits_sat");

      // Reset while the refill is waiting for memory.
      @(posedge clk); #1;
      cpu_req = 1'b1; cpu_we = 1'b0; hit = 1'b0; victim_dirty = 1'b0;
      cpu_addr = 32'h0000_0444; mem_ack = 1'b0;
      seen_req = 1'b0;
      for (int cyc = 0; cyc < 20 && !seen_req; cyc++) begin
         @(negedge clk);
         seen_req = mem_req;
      end
      chk("rst_test_req_seen", 64'(seen_req), 64'd1);
      @(posedge clk); #1;
      rst = 1'b1; cpu_req = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_hit = 0; m_miss = 0; m_wb = 0;
      @(negedge clk);
      chk("midrst_mem_req", 64'(mem_req), 64'd0);
      chk("midrst_stall",   64'(stall),   64'd0);
      check_counters("midrst");
      mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      @(negedge clk);
      chk("late_ack_mem_req", 64'(mem_req), 64'd0);
      chk("late_ack_fill_en", 64'(fill_en), 64'd0);
      chk("late_ack_stall",   64'(stall),   64'd0);
      mem_ack = 1'b0;
      do_miss(1'b0, 1'b1, 32'h0000_0444, 32'h0000_0C44, 32'h7777_1111, 32'h2468_ACE0, 1, 1);

      // Randomised mix of misses, hit bursts and idle gaps.
      for (int it = 0; it < 40; it++) begin
         case ($urandom_range(0, 2))
            0: do_miss(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                       $urandom, $urandom, $urandom,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            1: do_hits(int'($urandom_range(1, 4)));
            default: do_idle(int'($urandom_range(1, 3)));
         endcase
      end
      check_counters("final");

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
